// File: rtl/feram_state_loader_if.sv
// FeRAM read port plus block-output handshake for feram_state_loader.
// master: loader side (drives reads and vectors); slave: memory/array side.
interface feram_state_loader_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [127:0]      state_out;
  logic [127:0]      key_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_rd_en, mem_addr,
    output state_out, key_out, out_valid,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    input  state_out, key_out, out_valid,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/feram_state_loader.sv
// Loads a 16B AES state + 16B round key from byte-wide FeRAM into 128b vectors.
// Ports: clk, rst_n, start/state_addr/key_addr request, busy, bus (mem + out).
module feram_state_loader #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] state_addr,
  input  logic [ADDR_W-1:0] key_addr,
  output logic              busy,
  feram_state_loader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD
  } st_e;

  st_e               st_q, st_d;
  logic [4:0]        idx_q;
  logic [ADDR_W-1:0] sa_q, ka_q;
  logic [ADDR_W-1:0] off;
  logic [5:0]        tag_q [RD_LAT];
  logic [5:0]        ret;
  logic [127:0]      st_out_q, key_out_q;
  logic              fetch;

  assign fetch = (st_q == FETCH);
  assign ret   = tag_q[RD_LAT-1];
  assign off   = {{(ADDR_W-4){1'b0}}, idx_q[3:0]};

  assign bus.mem_rd_en = fetch;
  assign bus.mem_addr  = fetch ?
    ((idx_q[4] ? ka_q : sa_q) + off) : '0;
  assign bus.state_out = st_out_q;
  assign bus.key_out   = key_out_q;
  assign bus.out_valid = (st_q == HOLD);
  assign busy          = (st_q != IDLE);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:  if (start) st_d = FETCH;
      FETCH: if (idx_q == 5'd31) st_d = DRAIN;
      // last return is the tag carrying index 31
      DRAIN: if (ret[5] && ret[4:0] == 5'd31) st_d = HOLD;
      HOLD:  if (bus.out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      idx_q     <= '0;
      sa_q      <= '0;
      ka_q      <= '0;
      st_out_q  <= '0;
      key_out_q <= '0;
      for (int k = 0; k < RD_LAT; k++)
        tag_q[k] <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == IDLE && start) begin
        sa_q  <= state_addr;
        ka_q  <= key_addr;
        idx_q <= '0;
      end else if (fetch) begin
        idx_q <= idx_q + 5'd1;
      end
      tag_q[0] <= {fetch, idx_q};
      for (int k = 1; k < RD_LAT; k++)
        tag_q[k] <= tag_q[k-1];
      if (ret[5]) begin
        if (ret[4])
          key_out_q[{ret[3:0], 3'b000} +: 8] <= bus.mem_rdata;
        else
          st_out_q[{ret[3:0], 3'b000} +: 8] <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_feram_state_loader.sv
// Directed bench: three loaders (RD_LAT 1/2/4) on identity FeRAM models.
// Checks address stream, latency, data, back-pressure, wrap, reset abort.
module tb_feram_state_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] state_addr = '0;
  logic [7:0] key_addr = '0;
  logic       out_ready = 1'b0;
  logic       busy1, busy2, busy4;
  int         total = 0;
  int         bad = 0;
  logic [7:0] mem [256];
  logic [7:0] p1 [1];
  logic [7:0] p2 [2];
  logic [7:0] p4 [4];

  always #5 clk = ~clk;

  feram_state_loader_if #(.ADDR_W(8)) b1 ();
  feram_state_loader_if #(.ADDR_W(8)) b2 ();
  feram_state_loader_if #(.ADDR_W(8)) b4 ();

  feram_state_loader #(.ADDR_W(8), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_addr(state_addr), .key_addr(key_addr),
    .busy(busy1), .bus(b1.master)
  );
  feram_state_loader #(.ADDR_W(8), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_addr(state_addr), .key_addr(key_addr),
    .busy(busy2), .bus(b2.master)
  );
  feram_state_loader #(.ADDR_W(8), .RD_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .state_addr(state_addr), .key_addr(key_addr),
    .busy(busy4), .bus(b4.master)
  );

  assign b1.out_ready = out_ready;
  assign b2.out_ready = out_ready;
  assign b4.out_ready = out_ready;
  assign b1.mem_rdata = p1[0];
  assign b2.mem_rdata = p2[1];
  assign b4.mem_rdata = p4[3];

  always @(posedge clk) begin
    p1[0] <= b1.mem_rd_en ? mem[b1.mem_addr] : 8'h00;
    p2[0] <= b2.mem_rd_en ? mem[b2.mem_addr] : 8'h00;
    p2[1] <= p2[0];
    p4[0] <= b4.mem_rd_en ? mem[b4.mem_addr] : 8'h00;
    for (int k = 1; k < 4; k++)
      p4[k] <= p4[k-1];
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] v;
    logic [7:0]   a;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      a = base + 8'(k);
      v[8*k +: 8] = a;
    end
    return v;
  endfunction

  task automatic run_block(input logic [7:0] sa, input logic [7:0] ka,
                           input int hold_n, input bit poke);
    logic [127:0] es, ek;
    logic [7:0]   ea;
    logic         een;
    int           v1, v2, v4, bad_a, bad_s, hs_n;
    bit           done;
    es = mk(sa); ek = mk(ka);
    v1 = 0; v2 = 0; v4 = 0; bad_a = 0; bad_s = 0; hs_n = 0; done = 0;
    start = 1'b1; state_addr = sa; key_addr = ka;
    for (int n = 1; n <= 90 && !done; n++) begin
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b0;
      state_addr = 8'hC3; key_addr = 8'h3C;
      if (poke && n == 5) start = 1'b1;
      if (hs_n != 0) begin
        chk("hs_busy", busy2, 0);
        chk("hs_valid", {b1.out_valid, b2.out_valid, b4.out_valid}, 0);
        done = 1;
      end else begin
        een = (n <= 32);
        ea  = (n <= 16) ? sa + 8'(n - 1) :
              (n <= 32) ? ka + 8'(n - 17) : 8'h00;
        if (b2.mem_rd_en !== een) bad_a++;
        if (een && b2.mem_addr !== ea) bad_a++;
        if (busy2 !== 1'b1) bad_a++;
        if (b1.out_valid && v1 == 0) v1 = n;
        if (b2.out_valid && v2 == 0) v2 = n;
        if (b4.out_valid && v4 == 0) v4 = n;
        if (v2 != 0 && (b2.state_out !== es || b2.key_out !== ek ||
                        b2.out_valid !== 1'b1)) bad_s++;
        if (v1 != 0 && v2 != 0 && v4 != 0 && n >= v2 + hold_n) begin
          out_ready = 1'b1;
          hs_n = n;
          if (poke) start = 1'b1;
        end
      end
    end
    if (!done) chk("timeout", 0, 1);
    chk("addr_seq", bad_a, 0);
    chk("stable", bad_s, 0);
    chk("lat2", v2, 35);
    chk("lat1", v1, 34);
    chk("lat4", v4, 37);
    chk("state1", b1.state_out, es);
    chk("key1", b1.key_out, ek);
    chk("state4", b4.state_out, es);
    chk("key4", b4.key_out, ek);
    bad_a = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b0;
      if (b2.mem_rd_en !== 1'b0 || busy2 !== 1'b0) bad_a++;
    end
    chk("idle_after", bad_a, 0);
    chk("keep_state", b2.state_out, es);
  endtask

  initial begin
    int nv;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    #2;
    chk("rst_rd_en", b2.mem_rd_en, 0);
    chk("rst_addr", b2.mem_addr, 0);
    chk("rst_state", b2.state_out, 0);
    chk("rst_key", b2.key_out, 0);
    chk("rst_valid", b2.out_valid, 0);
    chk("rst_busy", busy2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(8'h10, 8'h40, 0, 0);
    chk("basic_state", b2.state_out,
        128'h1F1E1D1C1B1A19181716151413121110);
    chk("basic_key", b2.key_out,
        128'h4F4E4D4C4B4A49484746454443424140);

    run_block(8'h20, 8'h90, 10, 0);
    run_block(8'hF8, 8'h30, 0, 0);
    chk("wrap_b8", b2.state_out[71:64], 0);
    chk("wrap_b7", b2.state_out[63:56], 8'hFF);
    run_block(8'h55, 8'hAA, 2, 1);

    start = 1'b1; state_addr = 8'h60; key_addr = 8'h70;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_rst_rd_en", b2.mem_rd_en, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_rd_en", b2.mem_rd_en, 0);
    chk("mid_rst_addr", b2.mem_addr, 0);
    chk("mid_rst_state", b2.state_out, 0);
    chk("mid_rst_key", b2.key_out, 0);
    chk("mid_rst_valid", b2.out_valid, 0);
    chk("mid_rst_busy", busy2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge clk); #1;
      if (b1.out_valid || b2.out_valid || b4.out_valid ||
          b2.mem_rd_en || busy2) nv++;
    end
    chk("post_rst_quiet", nv, 0);
    chk("post_rst_state", b2.state_out, 0);
    run_block(8'h60, 8'h70, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feram_state_loader.md
Name: feram_state_loader

Overview:
- Upstream feeder for the 4x4 AES systolic array.
- Fetches a 16-byte state block and a 16-byte round key from the byte-wide FeRAM read port, one byte per cycle, and assembles them into 128-bit vectors.
- Presents both vectors to the array's data_n_rc / key_rc inputs under a valid/ready handshake.
- Byte k of each block drives array position row r = k%4, column c = k/4 (AES column-major order).

Parameters:
- ADDR_W, 8, FeRAM byte-address width.
- RD_LAT, 2, fixed FeRAM read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to load a state/key pair; honoured only in IDLE.
- state_addr  input  ADDR_W  base address of the 16 state bytes; sampled with start.
- key_addr  input  ADDR_W  base address of the 16 key bytes; sampled with start.
- mem_rd_en  output  1  FeRAM read strobe.
- mem_addr  output  ADDR_W  FeRAM read address.
- mem_rdata  input  8  FeRAM read data; valid RD_LAT cycles after the matching strobe.
- state_out  output  128  assembled state; byte k at bits [8k+7:8k].
- key_out  output  128  assembled key; same byte mapping as state_out.
- out_valid  output  1  state_out/key_out complete and stable.
- out_ready  input  1  array accepts the block.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous active-low. Every output goes to 0: mem_rd_en, mem_addr, state_out, key_out, out_valid, busy. The FSM enters IDLE, all counters clear, and the return-tag pipeline is flushed. Data returning after reset deasserts is ignored.
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - start=1 at cycle T latches state_addr and key_addr and moves to FETCH.
  - start=0 leaves the FSM in IDLE.
- FETCH:
  - Runs for exactly 32 consecutive cycles, T+1 .. T+32, with mem_rd_en=1 on each.
  - Issue index i = 0..31 (5-bit counter).
  - For i<16, mem_addr = state_addr+i. For i>=16, mem_addr = key_addr+(i-16).
  - Addition is modulo 2^ADDR_W, so addresses wrap past all-ones to 0.
  - After issue 31 the FSM moves to DRAIN, and mem_rd_en drops to 0 from T+33 onward.
- Return tracking:
  - A RD_LAT-deep shift register carries {valid, index[4:0]} for each issued read.
  - Byte for issue index i is captured on the edge ending cycle t+RD_LAT, where t is the issue cycle.
  - i<16 writes state_out byte i; i>=16 writes key_out byte i-16.
  - No stall or back-pressure exists on the memory side.
- DRAIN: waits until the index-31 return is captured (end of cycle T+32+RD_LAT), then moves to HOLD.
- HOLD:
  - out_valid=1 starting in cycle T+33+RD_LAT, so start-to-valid latency is 33+RD_LAT cycles.
  - state_out and key_out stay stable while out_valid=1 and out_ready=0; out_valid never drops without a handshake.
  - When out_valid & out_ready in cycle H, out_valid=0 and the FSM is in IDLE at H+1.
  - state_out and key_out keep their last values after the handshake until overwritten by the next fetch.
- busy = 1 in FETCH, DRAIN and HOLD.
- start outside IDLE is ignored, including in the handshake cycle. The earliest accepted next start is at H+1.
- out_ready asserted outside HOLD has no effect.
- Back-to-back blocks: minimum period is 34+RD_LAT cycles from one start to the next.
- Reset mid-FETCH or mid-HOLD aborts immediately; partial bytes are discarded, since outputs reset to 0.

Test Plan:
- Basic load, RD_LAT=2: memory holds byte value = address, state_addr=0x10, key_addr=0x40, start at T.
  -> mem_rd_en high T+1..T+32, addresses 0x10..0x1F then 0x40..0x4F.
  -> out_valid at T+35.
  -> state_out = 0x1F1E..1110, key_out = 0x4F4E..4140.
  -> out_ready=1 gives busy=0 next cycle.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid, then pulse it.
  -> out_valid and both vectors stable for all 10 cycles.
  -> Single transfer, then IDLE.
- Address wrap: state_addr=0xF8, ADDR_W=8.
  -> Addresses 0xF8..0xFF then 0x00..0x07.
  -> state_out byte 8 = mem[0x00].
- Start ignored: pulse start at T+5 and in the handshake cycle with different addresses.
  -> No new fetch, addresses unchanged, exactly one block delivered.
- Reset mid-FETCH: assert rst_n=0 at T+12 for 1 cycle.
  -> All outputs 0 immediately, no out_valid afterwards.
  -> New start after release loads correctly.
- Latency sweep: RD_LAT=1 and RD_LAT=4 with the first scenario's data.
  -> out_valid at T+34 and T+37 respectively, identical data.
